// File: rtl/perif_uart_pkg.sv
// Shared UART definitions used by the RX and TX peripherals.
package perif_uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_start = 2'd1,
      st_data  = 2'd2,
      st_stop  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/perif_uart_rx_fifo.sv
// Small synchronous circular-buffer FIFO with combinational head read.
// A push while full is rejected unless a pop happens in the same cycle.
module perif_uart_rx_fifo #(
   parameter int unsigned p_depth = 4,
   parameter int unsigned p_width = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push,
   input  logic [p_width-1:0] i_push_data,
   input  logic               i_pop,
   output logic [p_width-1:0] o_head,
   output logic               o_empty,
   output logic               o_full,
   output logic               o_overflow
);

   localparam int unsigned PTR_W = $clog2(p_depth);
   localparam int unsigned CNT_W = $clog2(p_depth + 1);

   logic [p_width-1:0] mem_q [p_depth];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic               pop_ok_s;
   logic               push_ok_s;

   // Qualify push/pop against occupancy and gate the head to zero when empty.
   always_comb begin
      o_empty    = (count_q == CNT_W'(1'b0));
      o_full     = (count_q == CNT_W'(p_depth));
      pop_ok_s   = i_pop && !o_empty;
      push_ok_s  = i_push && (!o_full || pop_ok_s);
      o_overflow = i_push && o_full && !pop_ok_s;
      if (o_empty) begin
         o_head = {p_width{1'b0}};
      end else begin
         o_head = mem_q[rd_ptr_q];
      end
   end

   // Storage, pointers and occupancy count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(p_depth); i++) begin
            mem_q[i] <= {p_width{1'b0}};
         end
         wr_ptr_q <= PTR_W'(1'b0);
         rd_ptr_q <= PTR_W'(1'b0);
         count_q  <= CNT_W'(1'b0);
      end else begin
         if (push_ok_s) begin
            mem_q[wr_ptr_q] <= i_push_data;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1'b1);
         end
         if (pop_ok_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_q <= count_q + CNT_W'(1'b1);
            2'b01:   count_q <= count_q - CNT_W'(1'b1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/perif_uart_rx.sv
// UART 8N1 receiver: two-flop line synchronizer, mid-bit sampling FSM,
// receive FIFO and sticky framing-error / overflow flags.
module perif_uart_rx
   import perif_uart_pkg::*;
#(
   parameter int unsigned p_fifo_depth = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [15:0] i_baudrate,
   input  logic        i_uart_rx,
   input  logic        i_rd_en,
   input  logic        i_clr_err,
   output logic [7:0]  o_rx_data,
   output logic        o_rx_valid,
   output logic        o_rx_full,
   output logic        o_frame_err,
   output logic        o_overflow,
   output logic        o_busy
);

   localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);

   logic                      sync1_q;
   logic                      sync2_q;
   logic                      rx_s;
   uart_state_e               state_q;
   logic [15:0]               baud_cnt_q;
   logic [BIT_IDX_W-1:0]      bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      frame_err_q;
   logic                      frame_err_d;
   logic                      overflow_q;
   logic                      overflow_d;
   logic                      half_s;
   logic                      end_s;
   logic                      push_s;
   logic                      ferr_set_s;
   logic                      drop_s;
   logic                      fifo_empty_s;
   logic                      fifo_full_s;

   assign rx_s = sync2_q;

   // Bring the asynchronous line into the clock domain; idles high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= i_uart_rx;
         sync2_q <= sync1_q;
      end
   end

   // Bit-timing strobes and the stop-bit decision (push or framing error).
   always_comb begin
      half_s     = (baud_cnt_q == (i_baudrate >> 1));
      end_s      = (baud_cnt_q == i_baudrate);
      push_s     = 1'b0;
      ferr_set_s = 1'b0;
      if (i_en && (state_q == st_stop) && end_s) begin
         if (rx_s) begin
            push_s = 1'b1;
         end else begin
            ferr_set_s = 1'b1;
         end
      end else begin
         push_s     = 1'b0;
         ferr_set_s = 1'b0;
      end
   end

   // Receive state machine: start validation, data sampling, stop check.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= st_idle;
         baud_cnt_q <= 16'd0;
         bit_idx_q  <= BIT_IDX_W'(1'b0);
         shift_q    <= {UART_DATA_BITS{1'b0}};
      end else if (!i_en) begin
         state_q    <= st_idle;
         baud_cnt_q <= 16'd0;
         bit_idx_q  <= BIT_IDX_W'(1'b0);
      end else begin
         case (state_q)
            st_idle: begin
               baud_cnt_q <= 16'd0;
               if (!rx_s) begin
                  state_q <= st_start;
               end
            end
            st_start: begin
               if (half_s) begin
                  baud_cnt_q <= 16'd0;
                  bit_idx_q  <= BIT_IDX_W'(1'b0);
                  // A high line at mid start bit was only a glitch.
                  state_q    <= rx_s ? st_idle : st_data;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            st_data: begin
               if (end_s) begin
                  shift_q[bit_idx_q] <= rx_s;
                  baud_cnt_q         <= 16'd0;
                  if (bit_idx_q == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
                     state_q <= st_stop;
                  end else begin
                     bit_idx_q <= bit_idx_q + BIT_IDX_W'(1'b1);
                  end
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            st_stop: begin
               // Leave at mid stop bit to gain half a bit of resync margin.
               if (end_s) begin
                  baud_cnt_q <= 16'd0;
                  state_q    <= st_idle;
               end else begin
                  baud_cnt_q <= baud_cnt_q + 16'd1;
               end
            end
            default: begin
               state_q    <= st_idle;
               baud_cnt_q <= 16'd0;
            end
         endcase
      end
   end

   // Sticky flag next-state: a set event wins over a simultaneous clear.
   always_comb begin
      frame_err_d = frame_err_q;
      overflow_d  = overflow_q;
      if (ferr_set_s) begin
         frame_err_d = 1'b1;
      end else if (i_clr_err) begin
         frame_err_d = 1'b0;
      end else begin
         frame_err_d = frame_err_q;
      end
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (i_clr_err) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Sticky flag registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   perif_uart_rx_fifo #(
      .p_depth (p_fifo_depth),
      .p_width (UART_DATA_BITS)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push_s),
      .i_push_data (shift_q),
      .i_pop       (i_rd_en),
      .o_head      (o_rx_data),
      .o_empty     (fifo_empty_s),
      .o_full      (fifo_full_s),
      .o_overflow  (drop_s)
   );

   assign o_rx_valid  = !fifo_empty_s;
   assign o_rx_full   = fifo_full_s;
   assign o_frame_err = frame_err_q;
   assign o_overflow  = overflow_q;
   assign o_busy      = (state_q != st_idle);

endmodule

// File: tb/tb_perif_uart_rx.sv
// Self-checking bench for perif_uart_rx. The bench plays the transmitter
// and keeps a queue-based model of what the receiver must hold.
module tb_perif_uart_rx;

   localparam int unsigned DEPTH = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_en;
   logic [15:0] i_baudrate;
   logic        i_uart_rx;
   logic        i_rd_en;
   logic        i_clr_err;
   logic [7:0]  o_rx_data;
   logic        o_rx_valid;
   logic        o_rx_full;
   logic        o_frame_err;
   logic        o_overflow;
   logic        o_busy;

   int errors = 0;
   int checks = 0;

   // Reference model state.
   logic [7:0] exp_q[$];
   bit         exp_ferr;
   bit         exp_ovf;

   perif_uart_rx #(.p_fifo_depth(DEPTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_baudrate(i_baudrate),
      .i_uart_rx(i_uart_rx), .i_rd_en(i_rd_en), .i_clr_err(i_clr_err),
      .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_full(o_rx_full),
      .o_frame_err(o_frame_err), .o_overflow(o_overflow), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Model: one complete frame arrives; optional pop at the same moment.
   function automatic void model_rx(input logic [7:0] d, input bit stop_hi, input bit pop_same);
      if (!stop_hi) begin
         exp_ferr = 1'b1;
      end else begin
         if (pop_same && exp_q.size() > 0) void'(exp_q.pop_front());
         if (exp_q.size() < DEPTH) exp_q.push_back(d);
         else exp_ovf = 1'b1;
      end
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame, LSB first, at the current baud setting.
   task automatic send_frame(input logic [7:0] d, input bit stop_hi);
      logic [9:0] fr;
      fr = {stop_hi, d, 1'b0};
      for (int k = 0; k < 10; k++) begin
         i_uart_rx = fr[k];
         tick(int'(i_baudrate) + 1);
      end
      i_uart_rx = 1'b1;
   endtask

   task automatic pop_one();
      i_rd_en = 1'b1;
      tick(1);
      i_rd_en = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic clr_err();
      i_clr_err = 1'b1;
      tick(1);
      i_clr_err = 1'b0;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
   endtask

   // Cycles from the line falling to the edge where the stop bit is sampled, minus one.
   function automatic int stop_offset();
      int b;
      b = int'(i_baudrate);
      return 12 + b / 2 + 9 * b;
   endfunction

   task automatic test_reset();
      i_rst = 1'b1; i_en = 1'b1; i_baudrate = 16'd9; i_uart_rx = 1'b1;
      i_rd_en = 1'b0; i_clr_err = 1'b0;
      tick(3);
      checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_rx_valid); end
      checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_rx_data); end
      checks++; if (o_rx_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", o_rx_full); end
      checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      i_rst = 1'b0;
      tick(3);
   endtask

   task automatic test_basic();
      int lat;
      i_baudrate = 16'd9;
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (o_rx_valid !== 1'b1 && lat < 300) begin
               tick(1);
               lat++;
            end
         end
      join
      model_rx(8'hA5, 1'b1, 1'b0);
      tick(5);
      checks++; if (lat < 97 || lat > 101) begin errors++; $display("FAIL basic_latency: got %0d cycles want 97..101", lat); end
      checks++; if (o_rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", o_rx_valid); end
      checks++; if (o_rx_data !== exp_q[0]) begin errors++; $display("FAIL basic_data: got %h want %h", o_rx_data, exp_q[0]); end
      pop_one();
      checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid: got %b want 0", o_rx_valid); end
      checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL basic_pop_data: got %h want 00", o_rx_data); end
   endtask

   task automatic test_random();
      logic [7:0] d;
      for (int n = 0; n < 6; n++) begin
         i_baudrate = 16'($urandom_range(2, 12));
         d = 8'($urandom);
         send_frame(d, 1'b1);
         model_rx(d, 1'b1, 1'b0);
         tick(8);
         checks++; if (o_rx_data !== exp_q[0] || o_rx_valid !== 1'b1) begin errors++; $display("FAIL random_data: got %h/%b want %h/1 baud %0d", o_rx_data, o_rx_valid, exp_q[0], i_baudrate); end
         pop_one();
         checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL random_pop: got %b want 0", o_rx_valid); end
      end
   endtask

   task automatic test_glitch();
      i_baudrate = 16'd9;
      i_uart_rx = 1'b0;
      tick(3);
      i_uart_rx = 1'b1;
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b want 1", o_busy); end
      tick(20);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b want 0", o_busy); end
      checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", o_rx_valid); end
      checks++; if (o_frame_err !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL glitch_flags: got %b%b want 00", o_frame_err, o_overflow); end
   endtask

   task automatic test_frame_err();
      int p;
      i_baudrate = 16'd9;
      send_frame(8'h3C, 1'b0);
      model_rx(8'h3C, 1'b0, 1'b0);
      tick(30);
      checks++; if (o_frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_set: got %b want %b", o_frame_err, exp_ferr); end
      checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_empty: got %b want 0", o_rx_valid); end
      clr_err();
      checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", o_frame_err); end
      // Clear pulse exactly on the failing stop-bit sample: set must win.
      p = stop_offset();
      fork
         send_frame(8'($urandom), 1'b0);
         begin
            tick(p);
            i_clr_err = 1'b1;
            tick(1);
            i_clr_err = 1'b0;
         end
      join
      exp_ferr = 1'b1;
      tick(30);
      checks++; if (o_frame_err !== exp_ferr) begin errors++; $display("FAIL ferr_set_wins: got %b want %b", o_frame_err, exp_ferr); end
      clr_err();
   endtask

   task automatic test_overflow();
      i_baudrate = 16'd5;
      for (int v = 1; v <= 5; v++) begin
         send_frame(8'(v), 1'b1);
         model_rx(8'(v), 1'b1, 1'b0);
      end
      tick(10);
      checks++; if (o_rx_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", o_rx_full); end
      checks++; if (o_overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %b want %b", o_overflow, exp_ovf); end
      for (int n = 0; n < DEPTH && exp_q.size() > 0; n++) begin
         checks++; if (o_rx_data !== exp_q[0]) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", n, o_rx_data, exp_q[0]); end
         pop_one();
      end
      checks++; if (o_rx_valid !== 1'b0 || o_rx_full !== 1'b0 || o_rx_data !== 8'h00) begin errors++; $display("FAIL ovf_empty: got v%b f%b d%h want v0 f0 d00", o_rx_valid, o_rx_full, o_rx_data); end
      clr_err();
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", o_overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] d;
      int p;
      i_baudrate = 16'($urandom_range(4, 10));
      for (int n = 0; n < DEPTH; n++) begin
         d = 8'($urandom);
         send_frame(d, 1'b1);
         model_rx(d, 1'b1, 1'b0);
      end
      tick(10);
      checks++; if (o_rx_full !== 1'b1) begin errors++; $display("FAIL fpp_full_before: got %b want 1", o_rx_full); end
      d = 8'($urandom);
      p = stop_offset();
      fork
         send_frame(d, 1'b1);
         begin
            tick(p);
            i_rd_en = 1'b1;
            tick(1);
            i_rd_en = 1'b0;
         end
      join
      model_rx(d, 1'b1, 1'b1);
      tick(10);
      checks++; if (o_overflow !== exp_ovf) begin errors++; $display("FAIL fpp_ovf: got %b want %b", o_overflow, exp_ovf); end
      checks++; if (o_rx_full !== 1'b1) begin errors++; $display("FAIL fpp_full_after: got %b want 1", o_rx_full); end
      for (int n = 0; n < DEPTH && exp_q.size() > 0; n++) begin
         checks++; if (o_rx_data !== exp_q[0]) begin errors++; $display("FAIL fpp_pop%0d: got %h want %h", n, o_rx_data, exp_q[0]); end
         pop_one();
      end
      checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", o_rx_valid); end
   endtask

   task automatic test_enable();
      logic [7:0] d;
      i_baudrate = 16'd7;
      fork
         send_frame(8'($urandom), 1'b1);
         begin
            tick(30);
            i_en = 1'b0;
            tick(1);
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL en_busy_off: got %b want 0", o_busy); end
         end
      join
      tick(10);
      i_en = 1'b1;
      tick(2);
      checks++; if (o_rx_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL en_discard: got v%b b%b want v0 b0", o_rx_valid, o_busy); end
      d = 8'($urandom);
      send_frame(d, 1'b1);
      model_rx(d, 1'b1, 1'b0);
      tick(8);
      checks++; if (o_rx_data !== exp_q[0] || o_rx_valid !== 1'b1) begin errors++; $display("FAIL en_resume: got %h/%b want %h/1", o_rx_data, o_rx_valid, exp_q[0]); end
      pop_one();
   endtask

   task automatic test_loopback();
      logic [7:0] bytes [3];
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
      i_baudrate = 16'd3;
      for (int n = 0; n < 3; n++) begin
         send_frame(bytes[n], 1'b1);
         model_rx(bytes[n], 1'b1, 1'b0);
      end
      tick(8);
      for (int n = 0; n < 3; n++) begin
         checks++; if (o_rx_data !== exp_q[0] || o_rx_valid !== 1'b1) begin errors++; $display("FAIL loop_byte%0d: got %h/%b want %h/1", n, o_rx_data, o_rx_valid, exp_q[0]); end
         pop_one();
      end
      checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL loop_empty: got %b want 0", o_rx_valid); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      i_baudrate = 16'd9;
      d = 8'($urandom);
      send_frame(d, 1'b1);
      model_rx(d, 1'b1, 1'b0);
      send_frame(8'($urandom), 1'b0);
      tick(30);
      fork
         send_frame(8'($urandom), 1'b1);
         begin
            tick(40);
            i_rst = 1'b1;
         end
      join
      tick(1);
      exp_q.delete(); exp_ferr = 1'b0; exp_ovf = 1'b0;
      checks++; if (o_rx_valid !== 1'b0 || o_rx_data !== 8'h00 || o_rx_full !== 1'b0) begin errors++; $display("FAIL rst_fifo: got v%b d%h f%b want v0 d00 f0", o_rx_valid, o_rx_data, o_rx_full); end
      checks++; if (o_frame_err !== 1'b0 || o_overflow !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rst_flags: got e%b o%b b%b want 000", o_frame_err, o_overflow, o_busy); end
      i_rst = 1'b0;
      tick(2);
      d = 8'($urandom);
      send_frame(d, 1'b1);
      model_rx(d, 1'b1, 1'b0);
      tick(8);
      checks++; if (o_rx_data !== exp_q[0] || o_rx_valid !== 1'b1) begin errors++; $display("FAIL rst_next_frame: got %h/%b want %h/1", o_rx_data, o_rx_valid, exp_q[0]); end
      pop_one();
   endtask

   initial begin
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      test_reset();
      test_basic();
      test_random();
      test_glitch();
      test_frame_err();
      test_overflow();
      test_full_push_pop();
      test_enable();
      test_loopback();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/perif_uart_rx.md
Name: perif_uart_rx

Overview:
UART receiver peripheral, the downstream counterpart of the UART TX peripheral on the SoC peripheral bus. It consumes an asynchronous 8N1 serial line and recovers bytes by mid-bit sampling. Bit timing comes from the same i_baudrate register as TX. Received bytes are buffered in a small FIFO that the bus-side register interface pops. It reports sticky framing-error and overflow flags.

Parameters:
p_fifo_depth, 4, receive FIFO depth in bytes; power of 2, at least 2.

Ports:
i_clk  input  1  global clock
i_rst  input  1  global reset; synchronous, active-high
i_en  input  1  receiver enable
i_baudrate  input  16  bit period minus 1, in clk cycles; same encoding as TX
i_uart_rx  input  1  asynchronous serial line; idles high
i_rd_en  input  1  pop FIFO head; ignored when empty
i_clr_err  input  1  clear o_frame_err and o_overflow
o_rx_data  output  8  FIFO head byte; 8'h00 when empty
o_rx_valid  output  1  FIFO non-empty
o_rx_full  output  1  FIFO holds p_fifo_depth bytes
o_frame_err  output  1  sticky: stop bit sampled low
o_overflow  output  1  sticky: byte received while FIFO full
o_busy  output  1  state != st_idle

Behaviour:
- Reset values: all outputs 0. The FIFO is empty and the state is st_idle. Both synchronizer flops are 1.
- Synchronizer: two flops on i_uart_rx. All logic uses the synchronized value rx_s, which lags the line by 2 cycles.
- Bit period is i_baudrate+1 cycles. baud_counter is 16 bits and counts 0..i_baudrate.
- Data format: LSB first, 8 data bits, no parity, 1 stop bit.
- State machine:
  - st_idle: on rx_s==0, go to st_start and set baud_counter to 0.
  - st_start: when baud_counter == i_baudrate>>1 (mid start bit), check rx_s.
    - rx_s==0: go to st_data; baud_counter<=0, bit_idx<=0.
    - rx_s==1: glitch; go to st_idle and store nothing.
  - st_data: when baud_counter == i_baudrate, write rx_s into shift[bit_idx] and set baud_counter<=0. After bit_idx 7 is sampled, go to st_stop.
  - st_stop: when baud_counter == i_baudrate, go to st_idle.
    - rx_s==1: push the byte.
    - rx_s==0: set o_frame_err and discard the byte.
  - Returning to idle at mid stop bit is intended; it gives half a bit of resync margin.
- Latency: o_rx_valid rises the cycle after the stop-bit sample.
- i_en low: state is forced to st_idle and counters clear. A frame in progress is discarded. FIFO contents and flags are retained, and pops still work.
- i_baudrate changing mid-frame is undefined. Software only changes it while o_busy==0.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo p_fifo_depth.
  - Count is $clog2(p_fifo_depth+1) bits wide.
  - Push when full: the byte is dropped, o_overflow is set, contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, the count is unchanged, no overflow.
  - Push and pop in the same cycle while empty: the pop is ignored, the push is accepted, and the count becomes 1.
  - o_rx_data is combinational from the head entry, gated to 0 when empty.
- Sticky flags: i_clr_err clears both. If a set event and i_clr_err occur in the same cycle, set wins.
- Reset mid-frame: reset returns every register to its reset value on the next clock edge, and the partial byte is lost.

Decomposition:
- Shared package perif_uart_pkg:
  - typedef uart_state_e {st_idle, st_start, st_data, st_stop}, shared with TX.
  - Localparam UART_DATA_BITS = 8.
- Sub-module perif_uart_rx_fifo: synchronous FIFO with push/pop, full/empty/count and combinational head read. It is reusable to replace the TX shift-FIFO later.

Test Plan:
- Basic receive: i_baudrate=9 (10 clk/bit), drive frame 0xA5 -> o_rx_valid rises 99 +/-2 cycles after the line falls, with o_rx_data=0xA5. Assert i_rd_en for 1 cycle -> o_rx_valid=0, o_rx_data=0x00.
- Start glitch: line low for 3 cycles, then high -> state returns to st_idle, o_rx_valid stays 0, no flag set.
- Framing error: frame 0x3C with stop bit held low -> o_frame_err=1 and FIFO empty. Pulse i_clr_err -> o_frame_err=0.
- Overflow: depth 4, send 0x01..0x05 with no reads -> o_rx_full=1, o_overflow=1, pops return 0x01,0x02,0x03,0x04, then empty.
- Full push+pop: FIFO full, stop-bit sample coincides with i_rd_en -> no overflow, count stays 4, the new byte lands at the tail.
- Loopback and reset: perif_uart_tx drives i_uart_rx at i_baudrate=3 for bytes 0x00, 0xFF, 0x55 -> identical bytes received. Assert i_rst mid-frame -> all outputs 0, and the next full frame is received correctly.
